// File: rtl/spi_poll_scheduler_pkg.sv
// Shared types and helpers for the SPI poll scheduler: FSM state encoding,
// default command byte and the slot-counter width rule.
package spi_poll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        SEND,
        WAIT_RX,
        NEXT
    } poll_state_e;

    localparam logic [7:0] CMD_BYTE_DEFAULT = 8'hA5;

    // A one-slot scheduler still needs a 1-bit slot register.
    function automatic int slot_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_poll_scheduler_if.sv
// User-side handshake of the SPI master. The scheduler drives requests
// through the master modport; the SPI master (or a bench) uses slave.
interface spi_poll_scheduler_if #(
    parameter int DATABITS = 8,
    parameter int SPI_SIZE = 2
);
    logic                o_TX_DV;
    logic [DATABITS-1:0] o_TX_Byte;
    logic [SPI_SIZE-1:0] o_SPI_Code;
    logic                i_TX_Ready;
    logic                i_RX_DV;
    logic [DATABITS-1:0] i_RX_Byte;

    modport master (
        output o_TX_DV, o_TX_Byte, o_SPI_Code,
        input  i_TX_Ready, i_RX_DV, i_RX_Byte
    );

    modport slave (
        input  o_TX_DV, o_TX_Byte, o_SPI_Code,
        output i_TX_Ready, i_RX_DV, i_RX_Byte
    );
endinterface

// File: rtl/spi_poll_scheduler_timer.sv
// Poll period timer: one-cycle tick every POLL_PERIOD enabled cycles, plus a
// single-entry pending flag for a tick that lands while the scheduler is busy.
module poll_timer #(
    parameter int POLL_PERIOD = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic busy,
    output logic tick,
    output logic pending
);
    localparam int CW = $clog2(POLL_PERIOD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          pend_q, pend_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(POLL_PERIOD - 1));

    // Pending only survives while busy; once the FSM is idle it either takes
    // the tick in WAIT_TICK or polling is off and the tick is meaningless.
    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        pend_d = 1'b0;
        if (enable) begin
            cnt_d  = wrap ? '0 : cnt_q + CW'(1);
            tick_d = wrap;
            pend_d = busy && (pend_q || tick_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
        end
    end

    assign tick    = tick_q;
    assign pending = pend_q;
endmodule

// File: rtl/spi_poll_scheduler.sv
// Round-robin SPI sensor poller: one command byte per slave per period, reply
// captured as that slave's reading. Define SPI_POLL_ALARM_EN for alarm outputs.
module spi_poll_scheduler
    import spi_poll_pkg::*;
#(
    parameter int                DATABITS    = 8,
    parameter int                SPI_SIZE    = 2,
    parameter int                N_SLAVES    = 2,
    parameter int                POLL_PERIOD = 1000,
    parameter logic [DATABITS-1:0] CMD_BYTE  = DATABITS'(CMD_BYTE_DEFAULT),
    parameter int                TIMEOUT     = 256,
    parameter logic [DATABITS-1:0] ALARM_THR = DATABITS'(8'hC8)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    spi_poll_scheduler_if.master         spi,
    output logic [N_SLAVES*DATABITS-1:0] readings,
    output logic [N_SLAVES-1:0]          valid,
    output logic [N_SLAVES-1:0]          timeout_err,
    output logic                         round_done,
`ifdef SPI_POLL_ALARM_EN
    output logic [N_SLAVES-1:0]          alarm,
`endif
    output logic                         busy
);
    localparam int SW = slot_width(N_SLAVES);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(N_SLAVES - 1);

    poll_state_e                          state_q;
    logic [SW-1:0]                        slot_q;
    logic [TW-1:0]                        tmo_q;
    logic [N_SLAVES-1:0][DATABITS-1:0]    rd_q;
    logic [N_SLAVES-1:0]                  valid_q;
    logic [N_SLAVES-1:0]                  terr_q;
    logic                                 rdone_q;
    logic [DATABITS-1:0]                  txb_q;
`ifdef SPI_POLL_ALARM_EN
    logic [N_SLAVES-1:0]                  alarm_q;
`endif

    logic tick, pending;

    assign busy = (state_q == SEND) || (state_q == WAIT_RX) || (state_q == NEXT);

    poll_timer #(.POLL_PERIOD(POLL_PERIOD)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .busy    (busy),
        .tick    (tick),
        .pending (pending)
    );

    // Request is taken in the very cycle the master reports ready.
    assign spi.o_TX_DV    = (state_q == SEND) && spi.i_TX_Ready;
    assign spi.o_TX_Byte  = txb_q;
    assign spi.o_SPI_Code = SPI_SIZE'(slot_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            slot_q  <= '0;
            tmo_q   <= '0;
            rd_q    <= '0;
            valid_q <= '0;
            terr_q  <= '0;
            rdone_q <= 1'b0;
            txb_q   <= '0;
`ifdef SPI_POLL_ALARM_EN
            alarm_q <= '0;
`endif
        end else begin
            rdone_q <= 1'b0;
            txb_q   <= CMD_BYTE;
            case (state_q)
                IDLE: begin
                    if (enable) state_q <= WAIT_TICK;
                end
                WAIT_TICK: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (tick || pending) begin
                        slot_q  <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (spi.i_TX_Ready) begin
                        tmo_q   <= TW'(TIMEOUT);
                        state_q <= WAIT_RX;
                    end
                end
                WAIT_RX: begin
                    // A reply on the expiry cycle still counts as a success.
                    if (spi.i_RX_DV) begin
                        rd_q[slot_q]    <= spi.i_RX_Byte;
                        valid_q[slot_q] <= 1'b1;
`ifdef SPI_POLL_ALARM_EN
                        alarm_q[slot_q] <= (spi.i_RX_Byte >= ALARM_THR);
`endif
                        state_q <= NEXT;
                    end else if (tmo_q == TW'(1)) begin
                        valid_q[slot_q] <= 1'b0;
                        terr_q[slot_q]  <= 1'b1;
`ifdef SPI_POLL_ALARM_EN
                        alarm_q[slot_q] <= 1'b0;
`endif
                        state_q <= NEXT;
                    end else begin
                        tmo_q <= tmo_q - TW'(1);
                    end
                end
                NEXT: begin
                    if (slot_q == LAST_SLOT) begin
                        rdone_q <= 1'b1;
                        state_q <= enable ? WAIT_TICK : IDLE;
                    end else if (enable) begin
                        slot_q  <= slot_q + SW'(1);
                        state_q <= SEND;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign readings    = rd_q;
    assign valid       = valid_q;
    assign timeout_err = terr_q;
    assign round_done  = rdone_q;
`ifdef SPI_POLL_ALARM_EN
    assign alarm       = alarm_q;
`endif
endmodule

// File: tb/tb_spi_poll_scheduler.sv
// Directed bench for spi_poll_scheduler: nominal rounds, ready backpressure,
// timeout, RX-on-expiry, enable drop, async reset and (optionally) alarms.
module tb_spi_poll_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] readings;
    logic [1:0]  valid;
    logic [1:0]  timeout_err;
    logic        round_done;
    logic        busy;
`ifdef SPI_POLL_ALARM_EN
    logic [1:0]  alarm;
`endif

    int nvec = 0;
    int nerr = 0;
    int n;
    int ntx;
    int nrd;

    always #5 clk = ~clk;

    spi_poll_scheduler_if #(.DATABITS(8), .SPI_SIZE(2)) spi ();

    spi_poll_scheduler #(
        .DATABITS(8), .SPI_SIZE(2), .N_SLAVES(2), .POLL_PERIOD(50),
        .CMD_BYTE(8'hA5), .TIMEOUT(16), .ALARM_THR(8'hC8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .spi         (spi),
        .readings    (readings),
        .valid       (valid),
        .timeout_err (timeout_err),
        .round_done  (round_done),
`ifdef SPI_POLL_ALARM_EN
        .alarm       (alarm),
`endif
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns the number of negedges until o_TX_DV is seen (or max).
    task automatic wait_txdv(input int max, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!spi.o_TX_DV && cnt < max);
    endtask

    task automatic reply(input int dly, input logic [7:0] b);
        repeat (dly) @(negedge clk);
        spi.i_RX_DV   = 1'b1;
        spi.i_RX_Byte = b;
        @(negedge clk);
        spi.i_RX_DV   = 1'b0;
        spi.i_RX_Byte = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; enable = 1'b0;
        spi.i_TX_Ready = 1'b1; spi.i_RX_DV = 1'b0; spi.i_RX_Byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_txdv",  spi.o_TX_DV, 0);
        chk("rst_txbyte", spi.o_TX_Byte, 0);
        chk("rst_code",  spi.o_SPI_Code, 0);
        chk("rst_read",  readings, 0);
        chk("rst_valid", valid, 0);
        chk("rst_terr",  timeout_err, 0);
        chk("rst_rdone", round_done, 0);
        chk("rst_busy",  busy, 0);

        // Round 1: nominal, first tick 50 cycles after enable, TX_DV one later
        rst = 1'b1; enable = 1'b1;
        wait_txdv(60, n);
        chk("first_lat", n, 51);
        chk("r1_code0", spi.o_SPI_Code, 0);
        chk("r1_txbyte", spi.o_TX_Byte, 8'hA5);
        chk("r1_busy", busy, 1);
        reply(10, 8'h3C);
        chk("r1_rd0", readings[7:0], 8'h3C);
        wait_txdv(5, n);
        chk("r1_next_lat", n, 1);
        chk("r1_code1", spi.o_SPI_Code, 1);
        reply(10, 8'h7E);
        chk("r1_read", readings, 16'h7E3C);
        chk("r1_valid", valid, 2'b11);
        chk("r1_rdone_pre", round_done, 0);
        @(negedge clk);
        chk("r1_rdone", round_done, 1);
        @(negedge clk);
        chk("r1_rdone_end", round_done, 0);

        // Round 2: ready held low 20 cycles in SEND, then slot 1 times out
        spi.i_TX_Ready = 1'b0;
        n = 0;
        while (!busy && n < 60) begin @(negedge clk); n++; end
        chk("bp_enter", busy, 1);
        for (int i = 0; i < 20; i++) begin
            chk("bp_hold", spi.o_TX_DV, 0);
            @(negedge clk);
        end
        spi.i_TX_Ready = 1'b1;
        #1;
        chk("bp_fire", spi.o_TX_DV, 1);
        chk("bp_code", spi.o_SPI_Code, 0);
        reply(10, 8'h3C);
        wait_txdv(5, n);
        chk("r2_slot1_lat", n, 1);
        repeat (16) @(negedge clk);
        chk("tmo_early", timeout_err, 2'b00);
        @(negedge clk);
        chk("tmo_terr", timeout_err, 2'b10);
        chk("tmo_valid", valid, 2'b01);
        chk("tmo_read", readings, 16'h7E3C);
        @(negedge clk);
        chk("tmo_rdone", round_done, 1);

        // Round 3: tick landed while busy, so the pending flag starts it at once
        wait_txdv(5, n);
        chk("pend_lat", n, 1);
        reply(16, 8'h55);
        chk("sim_read", readings[7:0], 8'h55);
        chk("sim_valid", valid, 2'b01);
        chk("sim_terr", timeout_err, 2'b10);
        wait_txdv(5, n);
        chk("r3_slot1_lat", n, 1);
        reply(10, 8'h7E);
        chk("r3_valid", valid, 2'b11);
        chk("r3_terr_sticky", timeout_err, 2'b10);
        chk("r3_read", readings, 16'h7E55);
        @(negedge clk);
        chk("r3_rdone", round_done, 1);

        // Round 4: enable drops during slot 0 WAIT_RX
        wait_txdv(60, n);
        chk("r4_txdv", spi.o_TX_DV, 1);
        chk("r4_code", spi.o_SPI_Code, 0);
        @(negedge clk);
        enable = 1'b0;
        reply(4, 8'h11);
        ntx = 0; nrd = 0;
        repeat (12) begin
            @(negedge clk);
            if (spi.o_TX_DV) ntx++;
            if (round_done)  nrd++;
        end
        chk("drop_no_tx", ntx, 0);
        chk("drop_no_rdone", nrd, 0);
        chk("drop_idle", busy, 0);
        chk("drop_read", readings[7:0], 8'h11);

        // Async reset in the middle of WAIT_RX
        enable = 1'b1;
        wait_txdv(60, n);
        chk("reen_lat", n, 51);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_read",  readings, 0);
        chk("arst_valid", valid, 0);
        chk("arst_terr",  timeout_err, 0);
        chk("arst_busy",  busy, 0);
        chk("arst_txdv",  spi.o_TX_DV, 0);
        chk("arst_txbyte", spi.o_TX_Byte, 0);
        chk("arst_code",  spi.o_SPI_Code, 0);

`ifdef SPI_POLL_ALARM_EN
        chk("arst_alarm", alarm, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_txdv(60, n);
        reply(10, 8'hC8);
        wait_txdv(5, n);
        reply(10, 8'hC7);
        chk("alarm_set", alarm, 2'b01);
        wait_txdv(60, n);
        chk("alarm_r2_txdv", spi.o_TX_DV, 1);
        repeat (17) @(negedge clk);
        chk("alarm_clr", alarm, 2'b00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/spi_poll_scheduler.md
Name: spi_poll_scheduler

Overview:
- Sequences the shared 1-master/N-slave SPI link.
- Periodically polls each sensor slave in round-robin order (slot 0 = LEV, slot 1 = POST): sends one command byte per slave and captures the full-duplex reply byte as that slave's latest reading.
- Sits between the SPI master's user interface (TX_DV/TX_Byte/SPI_Code/TX_Ready/RX_DV/RX_Byte) and the monitoring logic.
- Provides per-slave readings, valid flags and timeout flags.

Parameters:
- DATABITS, 8, width of SPI data bytes.
- SPI_SIZE, 2, width of the SPI slave-select code.
- N_SLAVES, 2, number of polled slaves (2..2**SPI_SIZE); slot k uses SPI_Code = k.
- POLL_PERIOD, 1000, clk cycles between round starts (>= 2).
- CMD_BYTE, 8'hA5, command byte sent to every slave.
- TIMEOUT, 256, cycles allowed in WAIT_RX before a slot is declared failed.
- ALARM_THR, 8'hC8, alarm threshold (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  polling enable; level-sensitive.
- o_TX_DV  out  1  one-cycle transfer request to the SPI master.
- o_TX_Byte  out  DATABITS  byte to transmit; equals CMD_BYTE.
- o_SPI_Code  out  SPI_SIZE  slave select for the current slot.
- i_TX_Ready  in  1  SPI master idle and able to accept a request.
- i_RX_DV  in  1  one-cycle strobe: received byte valid.
- i_RX_Byte  in  DATABITS  received byte.
- readings  out  N_SLAVES*DATABITS  latest reading; slot k occupies bits [k*DATABITS +: DATABITS].
- valid  out  N_SLAVES  bit k set when slot k's last poll succeeded.
- timeout_err  out  N_SLAVES  sticky; bit k set when slot k ever timed out; cleared only by reset.
- round_done  out  1  one-cycle pulse after the last slot of a round completes.
- busy  out  1  high in every state except IDLE and WAIT_TICK.

Behaviour:
- Reset values: all outputs 0; state IDLE; slot 0; period counter 0; pending tick 0.
- Period timer:
  - Runs only while enable=1.
  - Produces a one-cycle tick every POLL_PERIOD cycles; the first tick comes POLL_PERIOD cycles after enable rises.
  - A tick arriving while busy sets a single pending flag. Further ticks while it is pending are dropped (no queueing beyond one).
- FSM states and transitions:
  - IDLE: when enable=1, go to WAIT_TICK.
  - WAIT_TICK: on a tick or the pending flag, clear pending, set slot=0, go to SEND. If enable=0, go to IDLE.
  - SEND: drive o_SPI_Code=slot. In the first cycle with i_TX_Ready=1, assert o_TX_DV for exactly one cycle and go to WAIT_RX, loading the timeout counter with TIMEOUT. While i_TX_Ready=0, hold with o_TX_DV=0. SEND has no timeout.
  - WAIT_RX:
    - On i_RX_DV=1: write readings[slot]=i_RX_Byte and valid[slot]=1, go to NEXT.
    - On counter expiry: valid[slot]=0, timeout_err[slot]=1, go to NEXT.
    - If i_RX_DV and expiry occur in the same cycle, RX wins.
  - NEXT: if slot==N_SLAVES-1, pulse round_done and go to WAIT_TICK, or to IDLE if enable=0. Otherwise increment slot and go to SEND, or to IDLE if enable=0.
- Latency: from tick to o_TX_DV is 1 cycle (WAIT_TICK→SEND) plus any wait for i_TX_Ready.
- o_SPI_Code is held stable from SEND through NEXT.
- i_RX_DV outside WAIT_RX is ignored.
- Dropping enable mid-round:
  - The in-flight transfer (WAIT_RX) completes or times out first, then the FSM goes to IDLE.
  - Remaining slots are skipped; round_done is not pulsed.
- Async reset mid-transfer: every register returns to its reset value immediately; any SPI transfer in flight is abandoned.
- Slot counter width: clog2(N_SLAVES), with a minimum of 1. No wrap beyond N_SLAVES-1.

Optional Feature:
- Macro: SPI_POLL_ALARM_EN.
- Defined: adds an output port alarm, width N_SLAVES.
  - Bit k is registered and updates in the same cycle readings[k] is written: alarm[k] = (i_RX_Byte >= ALARM_THR).
  - A timeout on slot k clears alarm[k].
- Undefined: no alarm port and no comparator logic; ALARM_THR is unused.

Decomposition:
- Package spi_poll_pkg holds:
  - the state enum (IDLE, WAIT_TICK, SEND, WAIT_RX, NEXT);
  - the default CMD_BYTE constant;
  - a slot-width function (clog2 with a minimum of 1).
- Sub-module poll_timer (POLL_PERIOD, with inputs enable and busy):
  - outputs the one-cycle tick and the pending flag;
  - keeps the period counter and pending logic out of the main FSM.

Test Plan:
- Nominal round: N_SLAVES=2, POLL_PERIOD=50; bench slave model returns 8'h3C for slot 0 and 8'h7E for slot 1, with RX_DV 10 cycles after TX_DV.
  - Expect o_SPI_Code 0 then 1, o_TX_Byte=A5, readings=16'h7E3C, valid=2'b11, one round_done pulse per round.
- Ready backpressure: hold i_TX_Ready=0 for 20 cycles in SEND.
  - Expect o_TX_DV=0 throughout, then a single one-cycle o_TX_DV in the cycle ready rises.
- Timeout: slot 1 never returns RX_DV, TIMEOUT=16.
  - Expect slot 1 to leave WAIT_RX 16 cycles after TX_DV, valid=2'b01, timeout_err=2'b10 (sticky across later good rounds), round_done still pulsed.
- Simultaneous RX/expiry: assert i_RX_DV exactly on the expiry cycle with byte 8'h55.
  - Expect reading stored, valid bit set, timeout_err unchanged.
- Enable drop and reset: drop enable during slot 0 WAIT_RX.
  - Expect slot 0 to complete, no slot 1 request, no round_done, then IDLE.
  - Separately, assert rst low mid-WAIT_RX: expect all outputs 0 asynchronously.
- Alarm (macro defined, ALARM_THR=8'hC8): replies C8 and C7.
  - Expect alarm=2'b01; a subsequent timeout on slot 0 gives alarm=2'b00.
